memory_arbiter: RTL and testbench
=================================

# memory_arbiter

- Serves the cache side of the cache-control protocol.
- Accepts word-granular read/write requests from each CPU's icache and dcache and arbitrates them onto the single RAM port.
- Returns the per-requester wait/load responses the caches stall on.
- Sits between the caches and the RAM model; it is the responder end of the dcache/icache request interface.

## Interface
Parameters:
- CPUS, 2, number of CPUs; requester slots = 2*CPUS (slot 2c = dcache c, slot 2c+1 = icache c)

Ports:
- CLK  in  1  system clock; one clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  [CPUS]  icache read request
- iaddr  in  [CPUS] word_t  icache address
- iwait  out  [CPUS]  icache stall; low only in the cycle its read completes
- iload  out  [CPUS] word_t  icache read data
- dREN, dWEN  in  [CPUS]  dcache read / write request
- daddr, dstore  in  [CPUS] word_t  dcache address / write data
- dwait  out  [CPUS]  dcache stall; low only in the completing cycle
- dload  out  [CPUS] word_t  dcache read data
- ramREN, ramWEN  out  1  RAM strobes
- ramaddr, ramstore  out  word_t  RAM address / write data
- ramload  in  word_t  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR

## Operation
- Request from slot s means the slot's REN or WEN is high; dREN and dWEN both high is treated as a write.
- FSM states: IDLE, SERVE, BURST.
- IDLE:
  - rr_picker selects the first requesting slot at or after the pointer rr, wrapping modulo 2*CPUS.
  - If any slot is requesting, grant <= selected slot and the FSM goes to SERVE.
  - All RAM strobes are low.
- SERVE:
  - Drive ramREN/ramWEN, ramaddr and ramstore from the granted slot's live inputs.
  - If the granted slot drops its request, return to IDLE without completing and leave rr unchanged.
  - When ramstate==ACCESS: drop the granted slot's wait for that cycle.
    - If the grant is a dcache and daddr[2]==0, go to BURST (word 0 of a 2-word block).
    - Otherwise go to IDLE with rr <= grant+1.
- BURST:
  - Keep the grant and drive the RAM from the same dcache, so its word-1 access cannot be interleaved.
  - On ACCESS, drop that slot's wait, go to IDLE, rr <= grant+1.
  - If the dcache drops its request, go to IDLE with rr <= grant+1.
- BUSY, FREE and ERROR are all treated as "not done": waits stay high and the FSM does not advance.
- iload[c] and dload[c] pass ramload through combinationally for every c.
- Every non-granted slot's wait is held high.

## Timing
- Reset values: state=IDLE, grant=0, rr=0, all waits 1, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Request seen in IDLE at edge N → grant registered, RAM strobes asserted in cycle N+1.
- Completion occurs in the first SERVE/BURST cycle where ramstate==ACCESS; minimum latency request→wait low is 2 cycles.
- Wait low lasts exactly one cycle per completed word; load is valid in that cycle.
- A dcache block fill or writeback therefore costs grant cycle + two accesses, with no idle cycle between word 0 and word 1.
- Reset asserted mid-SERVE/BURST:
  - Outputs return to reset values immediately (asynchronous).
  - RAM strobes drop in the same cycle; no partial state is kept.
- A new request arriving in the completion cycle is not granted until the next IDLE cycle, giving one bubble between transactions.

## Structure
- cpu_types_pkg (already holds word_t and ramstate_t) gains:
  - arb_state_t {IDLE, SERVE, BURST}
  - slot index width constant $clog2(2*CPUS)
- Sub-module rr_picker: purely combinational; inputs are the request vector and rr, outputs are the valid flag and selected slot. Kept separate so it can be tested exhaustively.
- Registered state: state, grant, rr. Everything else is combinational.

## Test plan
- RAM model: ACCESS after 1 BUSY cycle.
- icache 0 reads 0x100, RAM returns 0xDEADBEEF → iwait[0] low exactly one cycle, 3 cycles after the request, with iload[0]=0xDEADBEEF.
- icache 0, dcache 0, icache 1 all request at reset → served in slot order dcache 0, icache 0, icache 1; rr=0 after the third completion.
- dcache 1 reads 0x200 then 0x204 while icache 0 requests continuously → both dcache words complete back-to-back with no icache access between them; icache 0 granted next.
- dcache 0 writes 0xCAFE0001 to 0x40 → ramWEN=1, ramaddr=0x40, ramstore=0xCAFE0001 during SERVE; dwait[0] low one cycle.
- Granted icache drops iREN before ACCESS → FSM returns to IDLE, no wait pulse, rr unchanged.
- nRST pulsed low during BURST → all waits 1, RAM strobes 0 immediately; after release a fresh request is served normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared cache/RAM types plus memory arbiter encodings
//   word_t      - 32-bit machine word
//   ramstate_t  - RAM model handshake state
//   arb_state_t - memory arbiter FSM state
//   slot_w()    - slot index width for 2*cpus requester slots
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, SERVE, BURST} arb_state_t;
  localparam int CPUS_DEF = 2;
  function automatic int slot_w(input int cpus);
    return $clog2(2 * cpus);
  endfunction
  localparam int SLOT_W = slot_w(CPUS_DEF);
endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first requesting slot at or after rr
//   req   in  [N]  per-slot request vector
//   rr    in  [W]  round-robin start pointer
//   valid out 1    any slot requesting
//   sel   out [W]  selected slot
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr,
  output logic         valid,
  output logic [W-1:0] sel
);
  logic [W-1:0] idx;
  int k;
  // Walk from the farthest candidate back to rr so the closest requester wins.
  always_comb begin
    valid = |req;
    sel = '0;
    idx = '0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(rr) + i) % N;
      idx = W'(k);
      if (req[idx]) sel = idx;
    end
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbitration of icache/dcache word requests onto one RAM port
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN/iaddr           icache read request/address per CPU
//   iwait/iload          icache stall (low in completing cycle) / read data
//   dREN/dWEN/daddr/dstore  dcache request, address, write data per CPU
//   dwait/dload          dcache stall (low in completing cycle) / read data
//   ramREN/ramWEN/ramaddr/ramstore  RAM strobes, address, write data
//   ramload/ramstate     RAM read data / handshake state
//   Slot 2c is dcache c, slot 2c+1 is icache c.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic      [CPUS-1:0]  iREN,
  input  word_t     [CPUS-1:0]  iaddr,
  output logic      [CPUS-1:0]  iwait,
  output word_t     [CPUS-1:0]  iload,
  input  logic      [CPUS-1:0]  dREN,
  input  logic      [CPUS-1:0]  dWEN,
  input  word_t     [CPUS-1:0]  daddr,
  input  word_t     [CPUS-1:0]  dstore,
  output logic      [CPUS-1:0]  dwait,
  output word_t     [CPUS-1:0]  dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  input  word_t                 ramload,
  input  ramstate_t             ramstate
);
  localparam int N = 2 * CPUS;
  localparam int W = slot_w(CPUS);
  arb_state_t state_q, state_d;
  logic [W-1:0] grant_q, grant_d, rr_q, rr_d, sel, grant_nxt;
  logic [N-1:0] req;
  logic valid, g_req, g_ren, g_wen, g_dc, done;
  word_t g_addr, g_store;
  rr_picker #(.N(N), .W(W)) u_pick (
    .req  (req),
    .rr   (rr_q),
    .valid(valid),
    .sel  (sel)
  );
  always_comb begin
    req = '0;
    for (int c = 0; c < CPUS; c++) begin
      req[2*c]   = dREN[c] | dWEN[c];
      req[2*c+1] = iREN[c];
    end
  end
  // Mux the granted slot's live inputs; a dcache with both strobes high is a write.
  always_comb begin
    g_req = 1'b0;
    g_ren = 1'b0;
    g_wen = 1'b0;
    g_addr = '0;
    g_store = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (grant_q == W'(2 * c)) begin
        g_req = dREN[c] | dWEN[c];
        g_wen = dWEN[c];
        g_ren = dREN[c] & ~dWEN[c];
        g_addr = daddr[c];
        g_store = dstore[c];
      end
      if (grant_q == W'(2 * c + 1)) begin
        g_req = iREN[c];
        g_ren = iREN[c];
        g_addr = iaddr[c];
      end
    end
  end
  assign g_dc = ~grant_q[0];
  assign grant_nxt = (grant_q == W'(N - 1)) ? '0 : grant_q + 1'b1;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    done = 1'b0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    if (state_q == IDLE) begin
      if (valid) begin
        grant_d = sel;
        state_d = SERVE;
      end
    end else begin
      ramREN = g_ren;
      ramWEN = g_wen;
      ramaddr = g_addr;
      ramstore = g_store;
      done = g_req && ramstate == ACCESS;
      if (!g_req) begin
        // Abandoning word 0 leaves rr alone; abandoning word 1 still retires the block.
        state_d = IDLE;
        rr_d = (state_q == BURST) ? grant_nxt : rr_q;
      end else if (done) begin
        state_d = (state_q == SERVE && g_dc && !g_addr[2]) ? BURST : IDLE;
        rr_d = (state_d == BURST) ? rr_q : grant_nxt;
      end
    end
  end
  always_comb begin
    for (int c = 0; c < CPUS; c++) begin
      dwait[c] = ~(done && grant_q == W'(2 * c));
      iwait[c] = ~(done && grant_q == W'(2 * c + 1));
      dload[c] = ramload;
      iload[c] = ramload;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized checking of memory_arbiter against a transaction model
module tb_memory_arbiter;
  import cpu_types_pkg::*;
  localparam int CPUS = 2;
  localparam int N = 2 * CPUS;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  word_t [CPUS-1:0] iaddr, daddr, dstore, iload, dload;
  logic ramREN, ramWEN;
  word_t ramaddr, ramstore, ramload;
  ramstate_t ramstate, nd_state;
  ramstate_t nd_opts[3] = '{FREE, BUSY, ERROR};
  word_t mem [0:255];
  int busy_left = 0;
  int ram_lat = 1;
  bit rand_lat = 0;
  bit rand_en = 0;
  int checks = 0;
  int errors = 0;
  bit a_act[N], a_wen[N], a_both[N], a_rep[N];
  word_t a_addr[N], a_store[N];
  int m_owner = -1;
  int m_rr = 0;
  bit m_word1 = 0;
  bit done_s[N];
  int comp_log[$];
  always #5 CLK = ~CLK;
  memory_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );
  // RAM model: ACCESS once busy_left non-ACCESS cycles of an active strobe have passed.
  assign ramload = mem[ramaddr[9:2]];
  assign ramstate = (busy_left == 0 && (ramREN || ramWEN)) ? ACCESS : nd_state;
  always @(posedge CLK) begin
    if (nRST && ramWEN && ramstate == ACCESS) mem[ramaddr[9:2]] <= ramstore;
    if (!(ramREN || ramWEN) || ramstate == ACCESS) busy_left <= rand_lat ? int'($urandom_range(0, 2)) : ram_lat;
    else busy_left <= busy_left - 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic drive();
    for (int c = 0; c < CPUS; c++) begin
      dREN[c] = a_act[2*c] && (!a_wen[2*c] || a_both[2*c]);
      dWEN[c] = a_act[2*c] && a_wen[2*c];
      daddr[c] = a_addr[2*c];
      dstore[c] = a_store[2*c];
      iREN[c] = a_act[2*c+1];
      iaddr[c] = a_addr[2*c+1];
    end
    nd_state = rand_lat ? nd_opts[$urandom_range(0, 2)] : BUSY;
  endtask
  function automatic bit slot_req(input int s);
    return (s % 2 == 1) ? iREN[s/2] : (dREN[s/2] | dWEN[s/2]);
  endfunction
  // One cycle of the reference: who owns the RAM port, what it must see, who completes.
  task automatic eval();
    bit er, ew;
    word_t ea, es, got_load;
    bit [N-1:0] wv;
    logic [CPUS-1:0] exp_d, exp_i;
    int s, t;
    er = 0; ew = 0; ea = '0; es = '0; wv = '1;
    for (int k = 0; k < N; k++) done_s[k] = 0;
    if (m_owner >= 0) begin
      s = m_owner;
      ea = (s % 2 == 1) ? iaddr[s/2] : daddr[s/2];
      es = dstore[s/2];
      ew = (s % 2 == 0) && dWEN[s/2];
      er = (s % 2 == 1) ? iREN[s/2] : (dREN[s/2] && !dWEN[s/2]);
      if (!(er || ew)) begin
        if (m_word1) m_rr = (s + 1) % N;
        m_owner = -1;
      end else if (busy_left == 0) begin
        wv[s] = 0;
        done_s[s] = 1;
        if (er) begin
          got_load = (s % 2 == 1) ? iload[s/2] : dload[s/2];
          check($sformatf("load slot%0d", s), got_load, mem[ea[9:2]]);
        end
        if (!m_word1 && s % 2 == 0 && !ea[2]) m_word1 = 1;
        else begin
          m_owner = -1;
          m_rr = (s + 1) % N;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        t = (m_rr + k) % N;
        if (m_owner < 0 && slot_req(t)) begin
          m_owner = t;
          m_word1 = 0;
        end
      end
    end
    for (int c = 0; c < CPUS; c++) begin
      exp_d[c] = wv[2*c];
      exp_i[c] = wv[2*c+1];
      if (!dwait[c]) comp_log.push_back(2 * c);
      if (!iwait[c]) comp_log.push_back(2 * c + 1);
    end
    check("ramREN", ramREN, er);
    check("ramWEN", ramWEN, ew);
    if (er || ew) check("ramaddr", ramaddr, ea);
    if (ew) check("ramstore", ramstore, es);
    check("dwait", 32'(dwait), 32'(exp_d));
    check("iwait", 32'(iwait), 32'(exp_i));
  endtask
  task automatic update();
    for (int s = 0; s < N; s++) begin
      if (done_s[s]) begin
        if (s % 2 == 0 && !a_addr[s][2]) begin
          a_addr[s][2] = 1'b1;
          a_store[s] = $urandom;
        end else if (!a_rep[s]) a_act[s] = 0;
      end else if (rand_en) begin
        if (a_act[s] && $urandom_range(0, 31) == 0) a_act[s] = 0;
        else if (!a_act[s] && $urandom_range(0, 3) == 0) begin
          a_act[s] = 1;
          a_addr[s] = word_t'($urandom_range(0, 255)) << 2;
          a_wen[s] = (s % 2 == 0) && ($urandom_range(0, 2) == 0);
          a_both[s] = 1'($urandom_range(0, 1));
          a_store[s] = $urandom;
        end
      end
    end
  endtask
  task automatic step();
    @(negedge CLK);
    drive();
    #1;
    eval();
    update();
  endtask
  function automatic bit any_act();
    bit r = 0;
    for (int s = 0; s < N; s++) r |= a_act[s];
    return r;
  endfunction
  task automatic run_idle(input string tag);
    int n = 0;
    while ((m_owner >= 0 || any_act()) && n < 300) begin
      step();
      n++;
    end
    check({tag, " settles"}, 32'(n < 300), 32'd1);
  endtask
  task automatic set_req(input int s, input word_t addr, input bit wen, input word_t data);
    a_act[s] = 1;
    a_addr[s] = addr;
    a_wen[s] = wen;
    a_both[s] = 0;
    a_store[s] = data;
    a_rep[s] = 0;
  endtask
  task automatic check_log(input string tag, input int exp[$]);
    check({tag, " count"}, comp_log.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s slot[%0d]", tag, i), (i < comp_log.size()) ? comp_log[i] : -1, exp[i]);
    comp_log.delete();
  endtask
  task automatic reset_all();
    nRST = 0;
    for (int s = 0; s < N; s++) begin
      a_act[s] = 0;
      a_rep[s] = 0;
    end
    m_owner = -1;
    m_rr = 0;
    m_word1 = 0;
    drive();
    #1;
    check("rst iwait", 32'(iwait), 32'(2**CPUS - 1));
    check("rst dwait", 32'(dwait), 32'(2**CPUS - 1));
    check("rst ramREN", ramREN, 0);
    check("rst ramWEN", ramWEN, 0);
    check("rst ramaddr", ramaddr, 0);
    check("rst ramstore", ramstore, 0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;
    comp_log.delete();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int q[$];
    int n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h40] = 32'hDEADBEEF;
    reset_all();
    set_req(1, 32'h100, 0, 0);
    run_idle("icache read");
    q = '{1};
    check_log("icache read", q);
    reset_all();
    set_req(1, 32'h100, 0, 0);
    set_req(0, 32'h24, 0, 0);
    set_req(3, 32'h108, 0, 0);
    run_idle("three req");
    q = '{0, 1, 3};
    check_log("three req", q);
    set_req(3, 32'h10C, 0, 0);
    set_req(1, 32'h110, 0, 0);
    run_idle("rr wrap");
    q = '{1, 3};
    check_log("rr wrap", q);
    set_req(2, 32'h200, 0, 0);
    set_req(1, 32'h100, 0, 0);
    a_rep[1] = 1;
    repeat (12) step();
    a_rep[1] = 0;
    run_idle("burst");
    q = '{1, 2, 2, 1};
    check({"burst", " count"}, 32'(comp_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) check($sformatf("burst slot[%0d]", i), (i < comp_log.size()) ? comp_log[i] : -1, q[i]);
    comp_log.delete();
    set_req(0, 32'h40, 1, 32'hCAFE0001);
    a_both[0] = 1;
    run_idle("write");
    check("write mem", mem[32'h40 >> 2], 32'hCAFE0001);
    q = '{0, 0};
    check_log("write", q);
    ram_lat = 3;
    set_req(1, 32'h100, 0, 0);
    step();
    step();
    a_act[1] = 0;
    run_idle("drop");
    ram_lat = 1;
    q = '{};
    check_log("drop", q);
    set_req(0, 32'h34, 0, 0);
    set_req(1, 32'h104, 0, 0);
    run_idle("after drop");
    q = '{1, 0};
    check_log("after drop", q);
    set_req(0, 32'h80, 0, 0);
    n = 0;
    while (!m_word1 && n < 20) begin
      step();
      n++;
    end
    check("reach burst", 32'(m_word1), 32'd1);
    @(negedge CLK);
    drive();
    #2;
    check("pre rst ramREN", ramREN, 1);
    nRST = 0;
    #1;
    check("async iwait", 32'(iwait), 32'(2**CPUS - 1));
    check("async dwait", 32'(dwait), 32'(2**CPUS - 1));
    check("async ramREN", ramREN, 0);
    check("async ramWEN", ramWEN, 0);
    reset_all();
    set_req(3, 32'h300, 0, 0);
    run_idle("post rst");
    q = '{3};
    check_log("post rst", q);
    rand_en = 1;
    rand_lat = 1;
    repeat (2000) step();
    rand_en = 0;
    run_idle("random");
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
